instr_fetch_queue: RTL

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one memory read at a time and buffers the
// returned {pc, instruction} pairs in a FIFO, with a registered head stage.
module instr_fetch_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_in,
  input  logic         pc_valid,
  output logic         pc_ready,
  input  logic         flush,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] instr_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, DRAIN} state_t;

  state_t         state_q, state_d;
  logic           mem_req_q, mem_req_d;
  logic [N-1:0]   mem_addr_q, mem_addr_d;
  logic           accept, push, pop, head_load;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [2*N-1:0] mem_q [DEPTH];
  logic           instr_valid_q;
  logic [N-1:0]   instr_out_q, instr_pc_q;

  // count_q covers the head register plus the storage array
  assign pc_ready  = (state_q == IDLE) && !flush && !reset && (count_q < CW'(DEPTH));
  assign accept    = pc_valid && pc_ready;
  assign pop       = instr_valid_q && instr_ready && !flush;
  assign head_load = !flush && (fifo_cnt_q != '0) && (!instr_valid_q || pop);

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = WAIT_ACK;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_in;
        end
      end
      WAIT_ACK: begin
        if (mem_ack) begin
          push      = !flush;
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_d    = count_q;
    fifo_cnt_d = fifo_cnt_q;
    if (flush) begin
      count_d    = '0;
      fifo_cnt_d = '0;
    end else begin
      count_d    = count_q + CW'(push) - CW'(pop);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(head_load);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      count_q       <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (flush) begin
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        instr_valid_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        // head data keeps its last value whenever nothing new is loaded
        if (head_load) begin
          rd_ptr_q                  <= rd_ptr_q + AW'(1);
          instr_valid_q             <= 1'b1;
          {instr_pc_q, instr_out_q} <= mem_q[rd_ptr_q];
        end else if (pop) begin
          instr_valid_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= {mem_addr_q, mem_rdata};
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;

endmodule
